// File: rtl/sdr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdr_pkg
// Purpose  : Shared types and constants for the SDR transmit serializer.
// Revision : 1.0 - initial release
// ============================================================================
package sdr_pkg;

    localparam int   DATA_W_DEF = 8;
    // T-bit polarity: 1 makes data+T carry an odd number of ones
    localparam logic ODD_PARITY = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_DONE   = 3'd4
    } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/sdr_byte_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sdr_byte_buffer
// Purpose  : One-entry hold register with valid/req handshake, pop and flush.
// Revision : 1.0 - initial release
// ============================================================================
module sdr_byte_buffer
    import sdr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic              req_o,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o
);

    logic              full_q;
    logic              full_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              w_accept;

    assign req_o    = en_i & ~full_q;
    assign w_accept = req_o & valid_i;
    assign full_o   = full_q;
    assign data_o   = data_q;

    // A flush wins over a same-cycle acceptance so nothing stale survives
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i || flush_i) begin
            full_d = 1'b0;
        end
        if (w_accept && !flush_i) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdr_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sdr_frame_serializer
// Purpose  : SDR transmit serializer: MSB-first data bits plus optional T-bit.
// Revision : 1.0 - initial release
// ============================================================================
module sdr_frame_serializer
    import sdr_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              i_ser_clk,
    input  logic              i_fcnt_rst_n,
    input  logic              i_ser_scl_neg,
    input  logic              i_ser_en,
    input  logic [DATA_W-1:0] i_ser_data,
    input  logic              i_ser_data_valid,
    output logic              o_ser_data_req,
    input  logic              i_ser_last_frame,
    output logic              o_ser_sda,
    output logic              o_ser_frame_done,
    output logic              o_ser_busy,
    output logic              o_ser_done,
    output logic              o_ser_err
);

    localparam int               c_CNT_W  = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_DW  = c_CNT_W'(DATA_W);
    localparam logic [c_CNT_W-1:0] c_CNT_LST = c_CNT_W'(DATA_W - 1);

    ser_state_e          state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [c_CNT_W-1:0]  cnt_q,   cnt_d;
    logic                sda_q,   sda_d;
    logic                tbit_q,  tbit_d;
    logic                fdone_q, fdone_d;
    logic                err_q,   err_d;

    logic                w_busy;
    logic                w_load;
    logic                w_flush;
    logic                w_buf_full;
    logic [DATA_W-1:0]   w_buf_data;

    assign w_busy = (state_q != ST_IDLE);

    sdr_byte_buffer #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk_i   (i_ser_clk),
        .rst_ni  (i_fcnt_rst_n),
        .en_i    (w_busy),
        .data_i  (i_ser_data),
        .valid_i (i_ser_data_valid),
        .pop_i   (w_load),
        .flush_i (w_flush),
        .req_o   (o_ser_data_req),
        .full_o  (w_buf_full),
        .data_o  (w_buf_data)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        sda_d   = sda_q;
        tbit_d  = tbit_q;
        fdone_d = 1'b0;
        err_d   = err_q;
        w_load  = 1'b0;
        w_flush = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sda_d = 1'b1;
                cnt_d = '0;
                if (i_ser_en) begin
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (i_ser_scl_neg && w_buf_full) begin
                    w_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (i_ser_scl_neg) begin
                    if (PARITY_EN && (cnt_q == c_CNT_DW)) begin
                        sda_d   = tbit_q;
                        fdone_d = 1'b1;
                        state_d = ST_PARITY;
                    end else begin
                        sda_d   = shift_q[DATA_W-1];
                        shift_d = shift_q << 1;
                        cnt_d   = cnt_q + c_CNT_ONE;
                        // Without a T-bit the frame ends on its last data bit
                        if (!PARITY_EN && (cnt_q == c_CNT_LST)) begin
                            fdone_d = 1'b1;
                            state_d = ST_PARITY;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (i_ser_scl_neg) begin
                    if (i_ser_last_frame) begin
                        sda_d   = 1'b1;
                        w_flush = 1'b1;
                        state_d = ST_DONE;
                    end else if (w_buf_full) begin
                        w_load = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        sda_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                w_flush = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shared frame-start path for FETCH and back-to-back PARITY reloads
        if (w_load) begin
            sda_d   = w_buf_data[DATA_W-1];
            shift_d = w_buf_data << 1;
            cnt_d   = c_CNT_ONE;
            tbit_d  = (^w_buf_data) ^ ODD_PARITY;
            state_d = ST_DATA;
        end
    end

    always_ff @(posedge i_ser_clk or negedge i_fcnt_rst_n) begin
        if (!i_fcnt_rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            sda_q   <= 1'b1;
            tbit_q  <= 1'b0;
            fdone_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            sda_q   <= sda_d;
            tbit_q  <= tbit_d;
            fdone_q <= fdone_d;
            err_q   <= err_d;
        end
    end

    assign o_ser_sda        = sda_q;
    assign o_ser_frame_done = fdone_q;
    assign o_ser_busy       = w_busy;
    assign o_ser_done       = (state_q == ST_DONE);
    assign o_ser_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sdr_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdr_frame_serializer
// Purpose  : Self-checking bench for sdr_frame_serializer (T-bit on and off).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdr_frame_serializer;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_neg;
    logic       en;
    logic       valid;
    logic       last;
    logic       sel_np;
    logic [7:0] data;

    logic sda_p, req_p, fd_p, busy_p, done_p, err_p;
    logic sda_n, req_n, fd_n, busy_n, done_n, err_n;
    logic sda, req, fdone, busy, done, err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    assign sda   = sel_np ? sda_n  : sda_p;
    assign req   = sel_np ? req_n  : req_p;
    assign fdone = sel_np ? fd_n   : fd_p;
    assign busy  = sel_np ? busy_n : busy_p;
    assign done  = sel_np ? done_n : done_p;
    assign err   = sel_np ? err_n  : err_p;

    sdr_frame_serializer #(.DATA_W(8), .PARITY_EN(1'b1)) u_dut_p (
        .i_ser_clk        (clk),
        .i_fcnt_rst_n     (rst_n),
        .i_ser_scl_neg    (scl_neg),
        .i_ser_en         (en & ~sel_np),
        .i_ser_data       (data),
        .i_ser_data_valid (valid),
        .o_ser_data_req   (req_p),
        .i_ser_last_frame (last),
        .o_ser_sda        (sda_p),
        .o_ser_frame_done (fd_p),
        .o_ser_busy       (busy_p),
        .o_ser_done       (done_p),
        .o_ser_err        (err_p)
    );

    sdr_frame_serializer #(.DATA_W(8), .PARITY_EN(1'b0)) u_dut_n (
        .i_ser_clk        (clk),
        .i_fcnt_rst_n     (rst_n),
        .i_ser_scl_neg    (scl_neg),
        .i_ser_en         (en & sel_np),
        .i_ser_data       (data),
        .i_ser_data_valid (valid),
        .o_ser_data_req   (req_n),
        .i_ser_last_frame (last),
        .o_ser_sda        (sda_n),
        .o_ser_frame_done (fd_n),
        .o_ser_busy       (busy_n),
        .o_ser_done       (done_n),
        .o_ser_err        (err_n)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sda"},  sda,   1'b1);
        chk({tag, "_req"},  req,   1'b0);
        chk({tag, "_fd"},   fdone, 1'b0);
        chk({tag, "_busy"}, busy,  1'b0);
        chk({tag, "_done"}, done,  1'b0);
    endtask

    // Reference: the wire image of each frame is its byte MSB first, then
    // (if enabled) a bit that makes the total count of ones odd.
    task automatic run(input bit pe, input byte_q_t bl, input int nlast,
                       input int abort_at, input bit noise, input string tag);
        byte_q_t q;
        bit      exp_bits[$];
        int      frame_len, nfr, total, k, fd, acc, cyc;
        bit      underflow, fin, req_pre, acc_now, scl_now;

        q         = bl;
        frame_len = pe ? 9 : 8;
        nfr       = (bl.size() < nlast) ? bl.size() : nlast;
        underflow = (bl.size() < nlast);
        for (int f = 0; f < nfr; f++) begin
            for (int i = 7; i >= 0; i--) exp_bits.push_back(bl[f][i]);
            if (pe) exp_bits.push_back(($countones(bl[f]) % 2) == 0);
        end
        total = nfr * frame_len;
        k = 0; fd = 0; acc = 0; cyc = 0; fin = 1'b0;

        sel_np = !pe;
        @(negedge clk);
        while (!fin && cyc < 1000) begin
            valid   = (q.size() > 0);
            data    = valid ? q[0] : 8'($urandom);
            last    = (fd >= nlast);
            en      = (cyc == 0) || (noise && (cyc % 5 == 2));
            scl_neg = (cyc % 4 == 3);
            scl_now = scl_neg;
            req_pre = req;
            @(posedge clk);
            acc_now = req_pre && valid;
            if (acc_now) begin
                void'(q.pop_front());
                acc++;
            end
            #1;
            if (fdone) fd++;
            if (acc_now) chk($sformatf("%s_reqdrop%0d", tag, acc), req, 1'b0);
            if (scl_now) begin
                if (k < total) begin
                    chk($sformatf("%s_sda%0d", tag, k), sda, exp_bits[k]);
                    chk($sformatf("%s_fd%0d", tag, k), fdone, ((k + 1) % frame_len) == 0);
                    chk($sformatf("%s_busy%0d", tag, k), busy, 1'b1);
                    if (k == abort_at) begin
                        #2 rst_n = 1'b0;
                        #1;
                        chk_idle({tag, "_abort"});
                        chk({tag, "_abort_err"}, err, 1'b0);
                        chk_int({tag, "_abort_fdcnt"}, fd, 0);
                        fin = 1'b1;
                    end
                end else begin
                    chk({tag, "_end_sda"}, sda, 1'b1);
                    if (underflow) begin
                        chk({tag, "_end_err"}, err, 1'b1);
                        chk({tag, "_end_busy"}, busy, 1'b0);
                    end else begin
                        chk({tag, "_end_done"}, done, 1'b1);
                    end
                    fin = 1'b1;
                end
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        scl_neg = 1'b0; en = 1'b0; valid = 1'b0; last = 1'b0;
        chk({tag, "_finished"}, fin, 1'b1);

        if (abort_at >= 0) begin
            rst_n = 1'b1;
            @(posedge clk); #1;
            chk_idle({tag, "_postrst"});
        end else begin
            chk_int({tag, "_frames"}, fd, nfr);
            chk_int({tag, "_accepted"}, acc, bl.size());
            @(posedge clk); #1;
            chk({tag, "_post_busy"}, busy, 1'b0);
            chk({tag, "_post_done"}, done, 1'b0);
            if (!underflow) chk({tag, "_post_err"}, err, 1'b0);
        end
    endtask

    initial begin
        byte_q_t b;
        int      n;

        rst_n = 1'b0; scl_neg = 1'b0; en = 1'b0; valid = 1'b0;
        last = 1'b0; data = 8'h00; sel_np = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("rst_p");
        chk("rst_p_err", err, 1'b0);
        sel_np = 1'b1;
        #1;
        chk_idle("rst_n");
        chk("rst_n_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        b.delete(); b.push_back(8'hA5);
        run(1'b1, b, 1, -1, 1'b0, "single_a5");

        b.delete(); b.push_back(8'h00); b.push_back(8'hFF); b.push_back(8'h3C);
        run(1'b1, b, 3, -1, 1'b0, "three");

        b.delete(); b.push_back(8'h96);
        run(1'b1, b, 2, -1, 1'b0, "underflow");
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        chk("uf_restart_err", err, 1'b0);
        chk("uf_restart_busy", busy, 1'b1);
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        b.delete(); b.push_back(8'hC3);
        run(1'b1, b, 1, 3, 1'b0, "abort");

        b.delete(); b.push_back(8'h81);
        run(1'b0, b, 1, -1, 1'b0, "nopar_81");

        b.delete(); b.push_back(8'h5A); b.push_back(8'h17);
        run(1'b1, b, 2, -1, 1'b1, "en_noise");

        for (int r = 0; r < 4; r++) begin
            b.delete();
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) b.push_back(8'($urandom));
            run(r[0], b, n, -1, r[1], $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sdr_frame_serializer.md
Name: sdr_frame_serializer

Overview:
- SDR transmit serializer for the I3C controller. Sits directly upstream of the SDR frame counter.
- Turns bytes from the TX data path into SDA bits: 8 data bits MSB first, then the T-bit.
- Emits a one-cycle frame-done strobe per completed frame, which drives the frame counter's enable.
- Consumes the counter's last-frame flag to decide whether to stop or continue.

Parameters:
- DATA_W, 8, data bits per frame.
- PARITY_EN, 1, 1 = append T-bit (odd parity); 0 = frames are DATA_W bits only.

Ports:
- i_ser_clk  input  1  system clock; all logic on rising edge.
- i_fcnt_rst_n  input  1  reset, asynchronous, active-low.
- i_ser_scl_neg  input  1  one-cycle pulse at each SCL falling edge; SDA changes only here.
- i_ser_en  input  1  start request, sampled in IDLE.
- i_ser_data  input  DATA_W  next byte to send.
- i_ser_data_valid  input  1  i_ser_data valid; accepted when o_ser_data_req is also high.
- o_ser_data_req  output  1  byte buffer empty, requesting a byte.
- i_ser_last_frame  input  1  last-frame flag from the frame counter.
- o_ser_sda  output  1  serial data to the SDA driver.
- o_ser_frame_done  output  1  one-cycle pulse when the last bit of a frame is driven.
- o_ser_busy  output  1  high in every state except IDLE.
- o_ser_done  output  1  one-cycle pulse on normal completion.
- o_ser_err  output  1  sticky underflow flag.

Behaviour:
- Reset values: o_ser_sda=1, o_ser_data_req=0, o_ser_frame_done=0, o_ser_busy=0, o_ser_done=0, o_ser_err=0, state=IDLE, bit counter=0, buffer empty.
- Reset mid-operation aborts immediately; SDA returns to 1 (released).
- Storage: shift register (DATA_W), one-entry hold buffer with full flag, bit counter of width clog2(DATA_W+1).
- Handshake: a byte transfers on any cycle where o_ser_data_req and i_ser_data_valid are both high. o_ser_data_req = busy AND buffer empty, so it deasserts the cycle after acceptance. Data must be stable while valid is high.
- States:
  - IDLE: SDA=1. When i_ser_en=1, clear o_ser_err and go to FETCH.
  - FETCH: wait for buffer full. On the first i_ser_scl_neg with buffer full: move buffer into shift register, drive bit DATA_W-1 on SDA, set bit count=1, go to DATA. Buffer becomes empty and o_ser_data_req rises.
  - DATA: on each i_ser_scl_neg, shift and drive the next bit, incrementing the count.
    - At count=DATA_W and PARITY_EN=1: drive T = ~^(frame byte), pulse o_ser_frame_done, go to PARITY.
    - At count=DATA_W and PARITY_EN=0: instead pulse o_ser_frame_done on the edge that drives the last data bit, then go to PARITY.
  - PARITY: hold SDA until the next i_ser_scl_neg, then:
    - i_ser_last_frame=1: SDA=1, go to DONE (buffer contents ignored and cleared).
    - else buffer full: load the next byte exactly as in FETCH, go to DATA (no gap frame).
    - else: underflow. Set o_ser_err=1, SDA=1, go to IDLE.
  - DONE: pulse o_ser_done for one cycle, go to IDLE.
- i_ser_last_frame is sampled only at the PARITY-exit edge. It is guaranteed settled, because the counter updates on the o_ser_frame_done rising edge at least one SCL period earlier.
- i_ser_scl_neg is ignored in IDLE and DONE.
- Simultaneous i_ser_scl_neg and byte acceptance in FETCH: the byte is not usable until the next edge.
- i_ser_en while busy is ignored.
- Frame timing: exactly DATA_W+PARITY_EN SCL edges per frame.

Decomposition:
- Shared package sdr_pkg: state enum (IDLE, FETCH, DATA, PARITY, DONE), DATA_W default, T-bit polarity constant ODD_PARITY=1.
- One sub-module is natural: sdr_byte_buffer (one-entry hold register with valid/req handshake and flush).

Test Plan:
- Single byte 0xA5, last_frame forced 1 after the first frame_done → SDA sequence 1,0,1,0,0,1,0,1,T=1; one frame_done pulse; done 1 edge later; busy low after.
- Three bytes 0x00,0xFF,0x3C with the frame counter model set to 3 frames → T-bits 1,1,1; back-to-back frames with no idle edge; 3 frame_done pulses, then done.
- Underflow: second byte withheld, last_frame=0 → at PARITY exit err=1, SDA=1, state IDLE; next i_ser_en clears err.
- Reset asserted mid-DATA after 4 bits → all outputs at reset values within the same cycle; no frame_done pulse.
- PARITY_EN=0, byte 0x81 → 8 edges per frame; frame_done on edge 8; no T-bit.
- i_ser_en pulsed while busy plus valid held high continuously → exactly one byte accepted per req window; transfer unaffected.
